// File: rtl/noc_inject_arbiter.sv
//------------------------------------------------------------------------------
// Module      : noc_inject_arbiter
// Description : Packet-locked round-robin arbiter feeding one router injection
//               port, with a single registered output stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module noc_inject_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_is_header,
    input  logic [NUM_REQ-1:0]            req_is_tail,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_flit,
    output logic                          out_is_header,
    output logic                          out_is_tail,
    output logic                          busy,
    output logic [IDX_W-1:0]              owner,
    output logic [CNT_W-1:0]              pkt_count
);

    localparam logic [IDX_W:0]   c_num  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_last = IDX_W'(NUM_REQ-1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_flit;
    logic                   r_out_hdr;
    logic                   r_out_tail;
    logic                   r_busy;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]       r_pkt_count;

    logic                   w_can_load;
    logic [NUM_REQ-1:0]     w_cand;
    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic [IDX_W:0]         w_idx;
    logic [IDX_W-1:0]       w_sel;
    logic                   w_grant;
    logic                   w_sel_valid;
    logic [DATA_WIDTH-1:0]  w_sel_flit;
    logic                   w_sel_hdr;
    logic                   w_sel_tail;
    logic                   w_accept;

    assign w_can_load = !r_out_valid || out_ready;
    assign w_cand     = req_valid & req_is_header;

    // Scan upward from the round-robin pointer; the first header candidate wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_idx >= c_num) begin
                w_idx = w_idx - c_num;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && w_cand[i] && (w_idx == (IDX_W+1)'(i))) begin
                    w_found  = 1'b1;
                    w_winner = IDX_W'(i);
                end
            end
        end
    end

    assign w_sel   = (r_state == ST_IDLE) ? w_winner : r_owner;
    // Ready is held low during reset so nothing is accepted while the lock clears.
    assign w_grant = noc_rst_n && w_can_load && ((r_state == ST_LOCKED) || w_found);

    always_comb begin
        req_ready   = '0;
        w_sel_valid = 1'b0;
        w_sel_flit  = '0;
        w_sel_hdr   = 1'b0;
        w_sel_tail  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                req_ready[i] = w_grant;
                w_sel_valid  = req_valid[i];
                w_sel_flit   = req_flit[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_hdr    = req_is_header[i];
                w_sel_tail   = req_is_tail[i];
            end
        end
    end

    assign w_accept = w_grant && w_sel_valid;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_hdr   <= 1'b0;
            r_out_tail  <= 1'b0;
            r_busy      <= 1'b0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_flit  <= w_sel_flit;
                r_out_hdr   <= w_sel_hdr;
                r_out_tail  <= w_sel_tail;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner  <= w_winner;
                        r_rr_ptr <= (w_winner == c_last) ? '0 : w_winner + 1'b1;
                        if (w_sel_tail) begin
                            r_pkt_count <= r_pkt_count + 1'b1;
                        end else begin
                            r_state <= ST_LOCKED;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && w_sel_tail) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_pkt_count <= r_pkt_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign out_flit      = r_out_flit;
    assign out_is_header = r_out_hdr;
    assign out_is_tail   = r_out_tail;
    assign busy          = r_busy;
    assign owner         = r_owner;
    assign pkt_count     = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_noc_inject_arbiter
// Description : Self-checking bench for noc_inject_arbiter with a packet-level
//               scoreboard and directed scenarios.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_noc_inject_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int IDX_W      = 2;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] d;
        logic                  h;
        logic                  t;
    } flit_t;

    logic                          noc_clk;
    logic                          noc_rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]            req_is_header;
    logic [NUM_REQ-1:0]            req_is_tail;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_flit;
    logic                          out_is_header;
    logic                          out_is_tail;
    logic                          busy;
    logic [IDX_W-1:0]              owner;
    logic [CNT_W-1:0]              pkt_count;

    noc_inject_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
        .req_is_header(req_is_header), .req_is_tail(req_is_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .out_is_header(out_is_header), .out_is_tail(out_is_tail),
        .busy(busy), .owner(owner), .pkt_count(pkt_count)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    int    checks = 0;
    int    errors = 0;

    flit_t txq[NUM_REQ][$];
    flit_t sbq[NUM_REQ][$];
    flit_t outq[$];
    int    out_cyc[$];
    int    grant_order[$];
    int    start_cyc[NUM_REQ];
    bit    gaps;
    int    ready_pct;
    int    stall_lo, stall_hi;
    int    busy_cycles, stall_cycles;

    task automatic clear_traffic();
        for (int i = 0; i < NUM_REQ; i++) begin
            txq[i].delete();
            start_cyc[i] = 0;
        end
        gaps      = 1'b0;
        ready_pct = 100;
        stall_lo  = -1;
        stall_hi  = -1;
    endtask

    task automatic do_reset();
        noc_rst_n     = 1'b0;
        req_valid     = '0;
        req_is_header = '0;
        req_is_tail   = '0;
        req_flit      = '0;
        out_ready     = 1'b0;
        repeat (3) @(negedge noc_clk);
        noc_rst_n = 1'b1;
    endtask

    // Drives queued flits, tracks every handshake and checks the output stream
    // against the packet order implied by the accepted headers.
    task automatic run_traffic(input int max_cyc);
        bit    pres[NUM_REQ];
        flit_t cur[NUM_REQ];
        int    waitc[NUM_REQ];
        bit    acc_prev, stall_prev, done, idle;
        flit_t acc_flit, hold, o;
        int    cur_src, pkt_i, cyc, acc_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            pres[i] = 1'b0; waitc[i] = 0; cur[i] = '0; sbq[i].delete();
        end
        outq.delete(); out_cyc.delete(); grant_order.delete();
        busy_cycles = 0; stall_cycles = 0;
        acc_prev = 0; stall_prev = 0; done = 0; cur_src = -1; pkt_i = 0; cyc = 0;
        acc_flit = '0; hold = '0;
        while (!done) begin
            @(negedge noc_clk);
            if (busy) busy_cycles++;
            if (acc_prev) begin
                checks++;
                if (out_valid !== 1'b1 || {out_flit, out_is_header, out_is_tail} !== acc_flit)
                    $display("FAIL latency: out v=%b flit=%h h=%b t=%b, required v=1 flit=%h h=%b t=%b",
                             out_valid, out_flit, out_is_header, out_is_tail, acc_flit.d, acc_flit.h, acc_flit.t);
                if (out_valid !== 1'b1 || {out_flit, out_is_header, out_is_tail} !== acc_flit) errors++;
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || {out_flit, out_is_header, out_is_tail} !== hold) begin
                    errors++;
                    $display("FAIL stall_hold: out v=%b flit=%h, required v=1 flit=%h", out_valid, out_flit, hold.d);
                end
            end
            idle = !out_valid;
            for (int i = 0; i < NUM_REQ; i++) if (pres[i] || txq[i].size() != 0) idle = 1'b0;
            if (idle) begin
                done = 1'b1;
            end else if (cyc >= max_cyc) begin
                checks++; errors++;
                $display("FAIL timeout: traffic not drained after %0d cycles, required drain", cyc);
                done = 1'b1;
            end else begin
                out_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 :
                            (int'($urandom_range(99)) < ready_pct);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pres[i] && txq[i].size() != 0 && cyc >= start_cyc[i] &&
                        (!gaps || $urandom_range(3) != 0)) begin
                        cur[i]  = txq[i].pop_front();
                        pres[i] = 1'b1;
                    end
                    req_valid[i]                           = pres[i];
                    req_flit[i*DATA_WIDTH +: DATA_WIDTH]   = pres[i] ? cur[i].d : $urandom;
                    req_is_header[i]                       = pres[i] ? cur[i].h : 1'($urandom);
                    req_is_tail[i]                         = pres[i] ? cur[i].t : 1'($urandom);
                end
                #1;
                acc_prev = 1'b0;
                checks++;
                if ($countones(req_ready) > 1) begin
                    errors++;
                    $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
                end
                if (out_valid && !out_ready) begin
                    stall_cycles++;
                    checks++;
                    if (req_ready !== '0) begin
                        errors++;
                        $display("FAIL stall_ready: req_ready=%b, required 0000", req_ready);
                    end
                end
                acc_i = -1;
                for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) acc_i = i;
                if (acc_i >= 0) begin
                    sbq[acc_i].push_back(cur[acc_i]);
                    acc_prev = 1'b1;
                    acc_flit = cur[acc_i];
                    if (cur[acc_i].h) begin
                        grant_order.push_back(acc_i);
                        for (int j = 0; j < NUM_REQ; j++) begin
                            if (j != acc_i && pres[j] && cur[j].h) begin
                                waitc[j]++;
                                checks++;
                                if (waitc[j] > NUM_REQ-1) begin
                                    errors++;
                                    $display("FAIL fairness: req%0d waited %0d packets, required <= %0d",
                                             j, waitc[j], NUM_REQ-1);
                                end
                            end
                        end
                        waitc[acc_i] = 0;
                    end
                    pres[acc_i] = 1'b0;
                end
                if (out_valid && out_ready) begin
                    o = {out_flit, out_is_header, out_is_tail};
                    outq.push_back(o);
                    out_cyc.push_back(cyc);
                    if (cur_src < 0) begin
                        if (pkt_i < grant_order.size()) begin
                            cur_src = grant_order[pkt_i];
                            pkt_i++;
                        end else begin
                            checks++; errors++;
                            $display("FAIL unexpected_out: flit=%h with no granted header pending", o.d);
                        end
                    end
                    if (cur_src >= 0) begin
                        checks++;
                        if (sbq[cur_src].size() == 0 || o !== sbq[cur_src][0]) begin
                            errors++;
                            $display("FAIL scoreboard: out flit=%h h=%b t=%b, required next flit of req%0d",
                                     o.d, o.h, o.t, cur_src);
                        end
                        if (sbq[cur_src].size() != 0) void'(sbq[cur_src].pop_front());
                        if (o.t) cur_src = -1;
                    end
                end
                stall_prev = out_valid && !out_ready;
                hold       = {out_flit, out_is_header, out_is_tail};
                cyc++;
            end
        end
        req_valid = '0; req_is_header = '0; req_is_tail = '0;
    endtask

    task automatic test_reset();
        noc_rst_n = 1'b0;
        req_valid = '1; req_is_header = '1; req_is_tail = '0; out_ready = 1'b1;
        repeat (2) @(negedge noc_clk);
        checks++;
        if (out_valid !== 1'b0 || out_flit !== '0 || out_is_header !== 1'b0 || out_is_tail !== 1'b0 ||
            busy !== 1'b0 || owner !== '0 || pkt_count !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b flit=%h h=%b t=%b busy=%b owner=%0d cnt=%0d rdy=%b, required all 0",
                     out_valid, out_flit, out_is_header, out_is_tail, busy, owner, pkt_count, req_ready);
        end
        do_reset();
    endtask

    task automatic test_single_packet();
        flit_t exp[3];
        do_reset(); clear_traffic();
        exp[0] = {32'hA1, 1'b1, 1'b0};
        exp[1] = {32'hA2, 1'b0, 1'b0};
        exp[2] = {32'hA3, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) txq[0].push_back(exp[k]);
        run_traffic(50);
        checks++;
        if (outq.size() != 3) begin
            errors++; $display("FAIL single_len: %0d flits out, required 3", outq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outq[k] !== exp[k]) begin
                    errors++; $display("FAIL single_flit%0d: %h, required %h", k, outq[k].d, exp[k].d);
                end
            end
            checks++;
            if (out_cyc[2] - out_cyc[0] != 2) begin
                errors++; $display("FAIL single_back2back: span %0d cycles, required 2", out_cyc[2] - out_cyc[0]);
            end
        end
        checks++;
        if (pkt_count !== 16'd1 || busy_cycles != 2) begin
            errors++; $display("FAIL single_count: cnt=%0d busy_cycles=%0d, required 1 and 2", pkt_count, busy_cycles);
        end
    endtask

    task automatic test_contention();
        do_reset(); clear_traffic();
        for (int i = 0; i < NUM_REQ; i++) begin
            txq[i].push_back({32'(8'hC0 + i), 1'b1, 1'b0});
            txq[i].push_back({32'(8'hD0 + i), 1'b0, 1'b1});
        end
        run_traffic(100);
        checks++;
        if (grant_order.size() != 4 || outq.size() != 8) begin
            errors++; $display("FAIL contention_len: grants=%0d flits=%0d, required 4 and 8",
                               grant_order.size(), outq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grant_order[k] != k || outq[2*k].d !== 32'(8'hC0 + k) || outq[2*k+1].d !== 32'(8'hD0 + k)) begin
                    errors++; $display("FAIL contention_order%0d: grant=%0d flits=%h,%h, required %0d",
                                       k, grant_order[k], outq[2*k].d, outq[2*k+1].d, k);
                end
            end
        end
        checks++;
        if (pkt_count !== 16'd4) begin
            errors++; $display("FAIL contention_count: %0d, required 4", pkt_count);
        end
        // Pointer should be back at requester 0: it must beat requester 1.
        clear_traffic();
        txq[1].push_back({32'hE1, 1'b1, 1'b1});
        txq[0].push_back({32'hE0, 1'b1, 1'b1});
        run_traffic(50);
        checks++;
        if (outq.size() != 2 || outq[0].d !== 32'hE0 || outq[1].d !== 32'hE1 || pkt_count !== 16'd6) begin
            errors++; $display("FAIL contention_ptr_wrap: first=%h cnt=%0d, required E0 and 6",
                               (outq.size() > 0) ? outq[0].d : 32'hx, pkt_count);
        end
    endtask

    task automatic test_fairness();
        do_reset(); clear_traffic();
        for (int p = 0; p < 3; p++) begin
            txq[1].push_back({32'(8'h11 + 2*p), 1'b1, 1'b0});
            txq[1].push_back({32'(8'h12 + 2*p), 1'b0, 1'b1});
        end
        txq[3].push_back({32'h31, 1'b1, 1'b0});
        txq[3].push_back({32'h32, 1'b0, 1'b1});
        start_cyc[3] = 2;
        run_traffic(100);
        checks++;
        if (grant_order.size() != 4 || grant_order[0] != 1 || grant_order[1] != 3 ||
            grant_order[2] != 1 || grant_order[3] != 1) begin
            errors++; $display("FAIL fairness_order: %0d grants, second=%0d, required 1,3,1,1",
                               grant_order.size(), (grant_order.size() > 1) ? grant_order[1] : -1);
        end
    endtask

    task automatic test_backpressure();
        do_reset(); clear_traffic();
        for (int k = 0; k < 4; k++) txq[0].push_back({32'(8'hB0 + k), k == 0, k == 3});
        stall_lo = 2; stall_hi = 7;
        run_traffic(60);
        checks++;
        if (stall_cycles != 5) begin
            errors++; $display("FAIL bp_stall_cycles: %0d, required 5", stall_cycles);
        end
        checks++;
        if (outq.size() != 4) begin
            errors++; $display("FAIL bp_len: %0d flits, required 4", outq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (outq[k].d !== 32'(8'hB0 + k)) begin
                    errors++; $display("FAIL bp_order%0d: %h, required %h", k, outq[k].d, 32'(8'hB0 + k));
                end
            end
        end
    endtask

    task automatic test_single_flit();
        do_reset(); clear_traffic();
        txq[0].push_back({32'h10, 1'b1, 1'b1});
        txq[2].push_back({32'h20, 1'b1, 1'b1});
        run_traffic(50);
        checks++;
        if (outq.size() != 2 || outq[0].d !== 32'h10 || outq[1].d !== 32'h20 || out_cyc[1] - out_cyc[0] != 1) begin
            errors++; $display("FAIL single_flit_seq: n=%0d, required 10 then 20 on consecutive cycles", outq.size());
        end
        checks++;
        if (busy_cycles != 0 || pkt_count !== 16'd2) begin
            errors++; $display("FAIL single_flit_state: busy_cycles=%0d cnt=%0d, required 0 and 2",
                               busy_cycles, pkt_count);
        end
    endtask

    task automatic test_orphan_and_reset();
        bit bad;
        do_reset();
        @(negedge noc_clk);
        out_ready = 1'b1;
        req_valid = 4'b0100; req_is_header = 4'b0000; req_is_tail = 4'b0100;
        req_flit  = {$urandom, $urandom, $urandom, $urandom};
        bad = 1'b0;
        repeat (8) begin
            #1;
            if (req_ready !== '0 || out_valid !== 1'b0) bad = 1'b1;
            @(negedge noc_clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL orphan: req_ready=%b out_valid=%b, required 0000 and 0", req_ready, out_valid);
        end
        req_valid = 4'b0110; req_is_header = 4'b0010;
        req_flit[1*DATA_WIDTH +: DATA_WIDTH] = 32'h51;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL orphan_grant: req_ready=%b, required 0010", req_ready);
        end
        @(negedge noc_clk);
        req_is_header = 4'b0000;
        req_flit[1*DATA_WIDTH +: DATA_WIDTH] = 32'h52;
        @(negedge noc_clk);
        checks++;
        if (busy !== 1'b1 || out_flit !== 32'h52 || owner !== 2'd1) begin
            errors++; $display("FAIL midpkt: busy=%b flit=%h owner=%0d, required 1, 52, 1", busy, out_flit, owner);
        end
        #2 noc_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_flit !== '0 || out_is_header !== 1'b0 || out_is_tail !== 1'b0 ||
            busy !== 1'b0 || owner !== '0 || pkt_count !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL async_reset: v=%b flit=%h busy=%b owner=%0d cnt=%0d rdy=%b, required all 0",
                               out_valid, out_flit, busy, owner, pkt_count, req_ready);
        end
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        req_valid = 4'b0001; req_is_header = 4'b0001; req_is_tail = 4'b0001;
        req_flit[0 +: DATA_WIDTH] = 32'h61;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL post_reset_grant: req_ready=%b, required 0001", req_ready);
        end
        @(negedge noc_clk);
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_flit !== 32'h61 || out_is_header !== 1'b1 || out_is_tail !== 1'b1 ||
            owner !== '0 || pkt_count !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_out: v=%b flit=%h owner=%0d cnt=%0d busy=%b, required 1, 61, 0, 1, 0",
                               out_valid, out_flit, owner, pkt_count, busy);
        end
    endtask

    task automatic test_random();
        int base, npkt, len;
        do_reset(); clear_traffic();
        gaps = 1'b1; ready_pct = 70; npkt = 0;
        base = int'(pkt_count);
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int p = 0; p < 6; p++) begin
                len = int'($urandom_range(4, 1));
                for (int f = 0; f < len; f++)
                    txq[i].push_back({8'(i), 8'(p), 16'($urandom), f == 0, f == len-1});
                npkt++;
            end
        end
        run_traffic(3000);
        checks++;
        if (pkt_count !== CNT_W'(base + npkt) || busy !== 1'b0) begin
            errors++; $display("FAIL random_count: cnt=%0d busy=%b, required %0d and 0", pkt_count, busy, base + npkt);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++;
            if (sbq[i].size() != 0) begin
                errors++; $display("FAIL random_drain: req%0d has %0d flits unforwarded, required 0", i, sbq[i].size());
            end
        end
    endtask

    initial begin
        noc_rst_n = 1'b0; req_valid = '0; req_is_header = '0; req_is_tail = '0;
        req_flit = '0; out_ready = 1'b0;
        test_reset();
        test_single_packet();
        test_contention();
        test_fairness();
        test_backpressure();
        test_single_flit();
        test_orphan_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
